neuron_mac_unit: RTL and testbench

- Single-neuron datapath driven by the MLP layer controller; one instance per neuron lane.
- On each neuron_start it clears and bias-loads its accumulator, then accumulates len+1 input×weight products.
- It then applies the optional ReLU, rescales and saturates the result, and presents it to the hidden/output layer registers.
- Consumes the controller's start pulse and term count (N convention: len = terms − 1).

---
 rtl/neuron_mac_unit.sv | 153 +++++++++++++++
 tb/tb_neuron_mac_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_unit.sv
// Single-neuron multiply-accumulate lane: it bias-loads the accumulator and sums len+1 x*w products.
// It then applies an optional ReLU, rescales, saturates and reports the result with a one-cycle done pulse.
module neuron_mac_unit #(
   parameter int DW    = 8,
   parameter int ACCW  = 24,
   parameter int CW    = 16,
   parameter int SHIFT = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [CW-1:0]          len,
   input  logic                   act_en,
   input  logic signed [DW-1:0]   bias,
   input  logic                   in_valid,
   input  logic signed [DW-1:0]   x,
   input  logic signed [DW-1:0]   w,
   output logic                   in_ready,
   output logic                   busy,
   output logic                   done,
   output logic signed [DW-1:0]   y,
   output logic signed [ACCW-1:0] acc_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_POST = 2'd2
   } state_t;

   localparam logic signed [ACCW-1:0] Y_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] Y_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
   localparam logic [CW-1:0]          CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   state_t                 state_q, state_d;
   logic signed [ACCW-1:0] acc_q, acc_d;
   logic [CW-1:0]          rem_q, rem_d;
   logic signed [DW-1:0]   y_q, y_d;
   logic                   done_q, done_d;
   logic                   act_q, act_d;
   logic                   in_ready_q, in_ready_d;
   logic                   busy_q, busy_d;

   logic signed [2*DW-1:0] prod_s;
   logic signed [ACCW-1:0] prod_ext_s;
   logic signed [ACCW-1:0] bias_init_s;
   logic signed [ACCW-1:0] scaled_s;

   // ReLU (when enabled) then clamp into the signed DW-bit output range.
   function automatic logic signed [DW-1:0] relu_sat(input logic signed [ACCW-1:0] v,
                                                     input logic relu);
      logic signed [ACCW-1:0] t;
      if (relu && v[ACCW-1]) begin
         t = {ACCW{1'b0}};
      end else begin
         t = v;
      end
      if (t > Y_MAX) begin
         return Y_MAX[DW-1:0];
      end else if (t < Y_MIN) begin
         return Y_MIN[DW-1:0];
      end else begin
         return t[DW-1:0];
      end
   endfunction

   assign prod_s      = x * w;
   assign prod_ext_s  = {{(ACCW-2*DW){prod_s[2*DW-1]}}, prod_s};
   assign bias_init_s = {{(ACCW-DW){bias[DW-1]}}, bias} <<< SHIFT;
   assign scaled_s    = acc_q >>> SHIFT;

   // Next-state and datapath update for the IDLE/ACC/POST sequence.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      rem_d      = rem_q;
      y_d        = y_q;
      done_d     = 1'b0;
      act_d      = act_q;
      in_ready_d = in_ready_q;
      busy_d     = busy_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d      = bias_init_s;
               rem_d      = len;
               act_d      = act_en;
               state_d    = S_ACC;
               in_ready_d = 1'b1;
               busy_d     = 1'b1;
            end else begin
               in_ready_d = 1'b0;
               busy_d     = 1'b0;
            end
         end
         S_ACC: begin
            if (in_valid) begin
               acc_d = acc_q + prod_ext_s;
               if (rem_q == {CW{1'b0}}) begin
                  state_d    = S_POST;
                  in_ready_d = 1'b0;
               end else begin
                  rem_d = rem_q - CNT_ONE;
               end
            end else begin
               acc_d = acc_q;
            end
         end
         S_POST: begin
            y_d        = relu_sat(scaled_s, act_q);
            done_d     = 1'b1;
            state_d    = S_IDLE;
            in_ready_d = 1'b0;
            busy_d     = 1'b0;
         end
         default: begin
            state_d    = S_IDLE;
            in_ready_d = 1'b0;
            busy_d     = 1'b0;
         end
      endcase
   end

   // State and output registers; async reset aborts any evaluation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         acc_q      <= {ACCW{1'b0}};
         rem_q      <= {CW{1'b0}};
         y_q        <= {DW{1'b0}};
         done_q     <= 1'b0;
         act_q      <= 1'b0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         rem_q      <= rem_d;
         y_q        <= y_d;
         done_q     <= done_d;
         act_q      <= act_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
      end
   end

   assign in_ready = in_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign y        = y_q;
   assign acc_out  = acc_q;

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Directed and randomized bench for neuron_mac_unit, checked against an arithmetic reference model.
module tb_neuron_mac_unit;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [15:0]         len;
   logic                act_en;
   logic signed [7:0]   bias;
   logic                in_valid;
   logic signed [7:0]   x;
   logic signed [7:0]   w;
   logic                in_ready;
   logic                busy;
   logic                done;
   logic signed [7:0]   y;
   logic signed [23:0]  acc_out;

   int passed = 0;
   int total  = 0;
   int failed = 0;
   int y_exp  = 0;
   int xq[$];
   int wq[$];
   int sq[$];

   neuron_mac_unit dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .act_en(act_en), .bias(bias),
      .in_valid(in_valid), .x(x), .w(w), .in_ready(in_ready), .busy(busy), .done(done),
      .y(y), .acc_out(acc_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Accumulator as the spec defines it: bias*2^7 plus all products, wrapped to 24 bits.
   function automatic longint model_acc(input int b, input int xs[$], input int ws[$]);
      longint a;
      a = longint'(b) * 128;
      foreach (xs[i]) a += longint'(xs[i]) * longint'(ws[i]);
      a = a & 64'hFFFFFF;
      if (a >= 64'sh800000) a -= 64'sh1000000;
      return a;
   endfunction

   function automatic int model_y(input longint a, input bit act);
      longint s;
      s = a >>> 7;
      if (act && s < 0) s = 0;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return int'(s);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one evaluation starting now; returns as soon as done is observed (or the bound expires).
   task automatic run_eval(input string tag, input int ln, input int b, input bit act,
                           input int xs[$], input int ws[$], input int stalls[$]);
      int     cyc;
      int     nstall;
      int     k;
      longint ea;
      int     ey;
      ea = model_acc(b, xs, ws);
      ey = model_y(ea, act);
      nstall = 0;
      start = 1'b1; len = 16'(ln); bias = 8'(b); act_en = act; in_valid = 1'b0;
      tick();
      cyc = 0;
      start = 1'b0; act_en = ~act; bias = 8'($urandom); len = 16'($urandom);
      check({tag, "_acc_init"}, acc_out, b * 128);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_done_low"}, done, 0);
      for (int i = 0; i < xs.size(); i++) begin
         for (int s = 0; s < stalls[i]; s++) begin
            in_valid = 1'b0; x = 8'($urandom); w = 8'($urandom);
            tick(); cyc++; nstall++;
         end
         if (ln < 16) begin
            check($sformatf("%s_in_ready_b%0d", tag, i), in_ready, 1);
            check($sformatf("%s_y_held_b%0d", tag, i), y, y_exp);
         end
         in_valid = 1'b1; x = 8'(xs[i]); w = 8'(ws[i]);
         tick(); cyc++;
      end
      in_valid = 1'b0;
      check({tag, "_post_in_ready"}, in_ready, 0);
      check({tag, "_post_busy"}, busy, 1);
      check({tag, "_acc"}, acc_out, 32'(ea));
      k = 0;
      while (done !== 1'b1 && k < 8) begin
         tick(); cyc++; k++;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_latency"}, cyc, ln + 2 + nstall);
      check({tag, "_y"}, y, ey);
      check({tag, "_idle_busy"}, busy, 0);
      y_exp = ey;
   endtask

   task automatic idle_check(input string tag);
      tick();
      check({tag, "_done_drop"}, done, 0);
      check({tag, "_y_hold"}, y, y_exp);
   endtask

   initial begin
      int n;
      int seen_done;
      rst = 1'b1; start = 1'b0; len = 16'd0; act_en = 1'b0; bias = 8'sd0;
      in_valid = 1'b0; x = 8'sd0; w = 8'sd0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_done", done, 0);
      check("rst_y", y, 0);
      check("rst_acc", acc_out, 0);
      rst = 1'b0;
      tick();

      xq = '{64, 64, 64, 64}; wq = '{64, 64, 64, 64}; sq = '{0, 0, 0, 0};
      run_eval("tp1", 3, 0, 1'b0, xq, wq, sq);
      check("tp1_acc_const", acc_out, 16384);
      check("tp1_y_const", y, 127);
      idle_check("tp1");

      xq = '{10, -5}; wq = '{20, 4}; sq = '{0, 3};
      run_eval("tp2", 1, 1, 1'b0, xq, wq, sq);
      check("tp2_acc_const", acc_out, 308);
      check("tp2_y_const", y, 2);
      idle_check("tp2");

      xq = '{-64}; wq = '{64}; sq = '{0};
      run_eval("tp3a", 0, 0, 1'b0, xq, wq, sq);
      check("tp3a_y_const", y, -32);
      idle_check("tp3a");
      run_eval("tp3b", 0, 0, 1'b1, xq, wq, sq);
      check("tp3b_y_const", y, 0);
      idle_check("tp3b");

      xq = '{-128, -128, -128, -128}; wq = '{127, 127, 127, 127}; sq = '{0, 0, 0, 0};
      run_eval("tp4", 3, 0, 1'b0, xq, wq, sq);
      check("tp4_acc_const", acc_out, -65024);
      check("tp4_y_const", y, -128);

      // Back-to-back: start lands in the done cycle.
      xq = '{3, -7, 100}; wq = '{9, 11, 50}; sq = '{0, 1, 0};
      run_eval("b2b1", 2, -3, 1'b0, xq, wq, sq);
      xq = '{-1}; wq = '{1}; sq = '{0};
      run_eval("b2b2", 0, 5, 1'b1, xq, wq, sq);
      idle_check("b2b2");

      for (int t = 0; t < 8; t++) begin
         xq.delete(); wq.delete(); sq.delete();
         n = $urandom_range(0, 6);
         for (int i = 0; i <= n; i++) begin
            xq.push_back($signed(8'($urandom)));
            wq.push_back($signed(8'($urandom)));
            sq.push_back($urandom_range(0, 2));
         end
         run_eval($sformatf("rnd%0d", t), n, $signed(8'($urandom)), 1'($urandom), xq, wq, sq);
         if ($urandom_range(0, 1) == 0) idle_check($sformatf("rnd%0d", t));
      end
      idle_check("rnd_end");

      // Spurious start during ACC, then reset mid-evaluation.
      start = 1'b1; len = 16'd5; bias = 8'sd3; act_en = 1'b0;
      tick();
      start = 1'b0;
      in_valid = 1'b1; x = 8'sd2; w = 8'sd3; tick();
      x = 8'sd4; w = 8'sd5; tick();
      in_valid = 1'b0; start = 1'b1; len = 16'd0; bias = 8'sd100; tick();
      start = 1'b0;
      check("ign_acc", acc_out, 410);
      check("ign_in_ready", in_ready, 1);
      in_valid = 1'b1; x = 8'sd1; w = 8'sd1;
      repeat (3) tick();
      check("ign_still_acc", in_ready, 1);
      check("ign_acc2", acc_out, 413);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_acc", acc_out, 0);
      check("mid_rst_y", y, 0);
      y_exp = 0;
      seen_done = 0;
      repeat (2) begin
         tick();
         if (done === 1'b1) seen_done++;
      end
      rst = 1'b0;
      repeat (4) begin
         tick();
         if (done === 1'b1) seen_done++;
      end
      in_valid = 1'b0;
      check("mid_rst_no_done", seen_done, 0);
      check("mid_rst_idle", busy, 0);

      // Full-length evaluation: 65536 beats, counter must not end early.
      xq.delete(); wq.delete(); sq.delete();
      for (int i = 0; i < 65536; i++) begin
         xq.push_back($urandom_range(0, 3) - 1);
         wq.push_back($urandom_range(0, 2) - 1);
         sq.push_back(0);
      end
      run_eval("maxlen", 65535, -2, 1'b0, xq, wq, sq);
      idle_check("maxlen");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
